// File: rtl/timer_pkg.sv
// Shared definitions for the timer counter stage: default widths and FSM state encoding.
package timer_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: counts 0..div_reg while enabled and asserts tick on the wrapping edge.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_reg,
  output logic             tick
);

  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic             at_term;

  // >= rather than == so a divider lowered under the current count wraps at once
  assign at_term = (presc_q >= div_reg);
  assign tick    = en && !clr && at_term;

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (!en || clr || at_term) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Main counter stage feeding timer_core: continuous / one-shot counting with optional prescaler.
// Define TIMER_PRESCALER_EN to instantiate the prescaler; otherwise the counter ticks every RUN cycle.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             chosen_clk,
  input  logic             rst,
  input  logic             core_en,
  input  logic             cont,
  input  logic             cnt_clr,
  input  logic [CNT_W-1:0] period_reg,
  input  logic [DIV_W-1:0] div_reg,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_tick,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             run_en;
  logic             tick;

  assign run_en = core_en && (state_q == ST_RUN);

`ifdef TIMER_PRESCALER_EN
  timer_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk    (chosen_clk),
    .rst    (rst),
    .en     (run_en),
    .clr    (cnt_clr),
    .div_reg(div_reg),
    .tick   (tick)
  );
`else
  logic unused_div;
  assign unused_div = ^div_reg;
  assign tick       = run_en && !cnt_clr;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (cnt_clr) begin
      // A clear swallows any tick due on the same edge
      cnt_d   = '0;
      state_d = core_en ? ST_RUN : ST_IDLE;
    end else if (!core_en) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            tick_d = 1'b1;
            if (cnt_q >= period_reg) begin
              if (cont) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: ;
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge chosen_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_tick = tick_q;
  assign wrap     = wrap_q;
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues expected tick results, a monitor checks each cnt_tick.
module tb_timer_counter;

`ifdef TIMER_PRESCALER_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  logic        chosen_clk = 1'b0;
  logic        rst        = 1'b0;
  logic        core_en    = 1'b0;
  logic        cont       = 1'b0;
  logic        cnt_clr    = 1'b0;
  logic [15:0] period_reg = '0;
  logic [7:0]  div_reg    = '0;
  logic [15:0] cnt;
  logic        cnt_tick;
  logic        wrap;
  logic        done;
  logic        busy;

  timer_counter dut (
    .chosen_clk(chosen_clk),
    .rst       (rst),
    .core_en   (core_en),
    .cont      (cont),
    .cnt_clr   (cnt_clr),
    .period_reg(period_reg),
    .div_reg   (div_reg),
    .cnt       (cnt),
    .cnt_tick  (cnt_tick),
    .wrap      (wrap),
    .done      (done),
    .busy      (busy)
  );

  always #5 chosen_clk = ~chosen_clk;

  typedef struct {
    logic [15:0] cnt;
    logic        wrap;
    logic        done;
    int          gap;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  int   last_tick = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int c, input logic w, input logic d, input int g);
    exp_t x;
    x.cnt  = c[15:0];
    x.wrap = w;
    x.done = d;
    x.gap  = g;
    q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge chosen_clk);
  endtask

  // Monitor: every cnt_tick must match the oldest queued expectation
  always @(posedge chosen_clk) begin
    #1;
    cyc_cnt++;
    if (cnt_tick) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_tick: got tick with cnt=%0d, expected none", cnt);
      end else begin
        e = q.pop_front();
        $display("tick: cnt=%0d wrap=%0b done=%0b (exp %0d/%0b/%0b)", cnt, wrap, done, e.cnt, e.wrap, e.done);
        chk("tick_cnt", 32'(cnt), 32'(e.cnt));
        chk("tick_wrap", 32'(wrap), 32'(e.wrap));
        chk("tick_done", 32'(done), 32'(e.done));
        if (e.gap != 0) chk("tick_gap", cyc_cnt - last_tick, e.gap);
      end
      last_tick = cyc_cnt;
    end else if (wrap) begin
      n_chk++;
      n_fail++;
      $display("FAIL wrap_no_tick: got wrap=1 with cnt_tick=0, expected wrap=0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b1;
    cyc(2);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_tick", 32'(cnt_tick), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc(1);

    // 1: free run, period 3
    div_reg = 8'd0; period_reg = 16'd3; cont = 1'b1; core_en = 1'b1;
    push(1, 0, 0, 0); push(2, 0, 0, 1); push(3, 0, 0, 1); push(0, 1, 0, 1); push(1, 0, 0, 1);
    cyc(1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cnt0", 32'(cnt), 0);
    cyc(5);
    chk("t1_done", 32'(done), 0);
    core_en = 1'b0;
    cyc(1);
    chk("t1_idle_busy", 32'(busy), 0);

    // 2: prescale div 2, period 5
    div_reg = 8'd2; period_reg = 16'd5; cont = 1'b1; core_en = 1'b1;
    push(1, 0, 0, 0);
    for (int i = 2; i <= 5; i++) push(i, 0, 0, D);
    push(0, 1, 0, D); push(1, 0, 0, D);
    cyc(1 + 7 * D);
    core_en = 1'b0;
    cyc(1);

    // 3: one-shot, period 4
    div_reg = 8'd0; period_reg = 16'd4; cont = 1'b0; core_en = 1'b1;
    for (int i = 1; i <= 4; i++) push(i, 0, 0, (i == 1) ? 0 : 1);
    push(4, 0, 1, 1);
    cyc(6);
    chk("t3_done", 32'(done), 1);
    chk("t3_busy", 32'(busy), 0);
    cyc(20);
    chk("t3_frozen_cnt", 32'(cnt), 4);
    chk("t3_still_done", 32'(done), 1);
    cnt_clr = 1'b1;
    cyc(1);
    chk("t3_clr_cnt", 32'(cnt), 0);
    chk("t3_clr_busy", 32'(busy), 1);
    chk("t3_clr_done", 32'(done), 0);
    cnt_clr = 1'b0; core_en = 1'b0;
    cyc(1);

    // 4: clear collides with tick at cnt=6
    period_reg = 16'd10; cont = 1'b1; core_en = 1'b1;
    for (int i = 1; i <= 6; i++) push(i, 0, 0, (i == 1) ? 0 : 1);
    push(1, 0, 0, 2); push(2, 0, 0, 1);
    cyc(7);
    chk("t4_cnt6", 32'(cnt), 6);
    cnt_clr = 1'b1;
    cyc(1);
    chk("t4_clr_cnt", 32'(cnt), 0);
    chk("t4_clr_tick", 32'(cnt_tick), 0);
    chk("t4_clr_wrap", 32'(wrap), 0);
    cnt_clr = 1'b0;
    cyc(2);
    core_en = 1'b0;
    cyc(1);

    // 5: period shrink at cnt=9, then period 0
    period_reg = 16'd20; cont = 1'b1; core_en = 1'b1;
    for (int i = 1; i <= 9; i++) push(i, 0, 0, (i == 1) ? 0 : 1);
    cyc(10);
    period_reg = 16'd5;
    push(0, 1, 0, 1);
    cyc(1);
    period_reg = 16'd0;
    push(0, 1, 0, 1); push(0, 1, 0, 1); push(0, 1, 0, 1);
    cyc(3);
    core_en = 1'b0;
    cyc(1);

    // 6a: async reset between edges at cnt=7
    period_reg = 16'd20; core_en = 1'b1;
    for (int i = 1; i <= 7; i++) push(i, 0, 0, (i == 1) ? 0 : 1);
    cyc(8);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cnt", 32'(cnt), 0);
    chk("t6_rst_tick", 32'(cnt_tick), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    core_en = 1'b0;
    @(negedge chosen_clk) rst = 1'b0;
    cyc(1);

    // 6b: disable at cnt=7
    core_en = 1'b1;
    for (int i = 1; i <= 7; i++) push(i, 0, 0, (i == 1) ? 0 : 1);
    cyc(8);
    chk("t6_run_cnt7", 32'(cnt), 7);
    core_en = 1'b0;
    cyc(1);
    chk("t6_dis_cnt", 32'(cnt), 0);
    chk("t6_dis_busy", 32'(busy), 0);
    chk("t6_dis_tick", 32'(cnt_tick), 0);

    cyc(2);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Main 16-bit counter stage feeding timer_core.
- Produces `cnt`, with optional prescaling of `chosen_clk`.
- Handles continuous and one-shot run modes, and honours the counter-clear request raised by timer_core.
- Sits between the clock-select mux and timer_core; all logic is on `chosen_clk`.

Parameters:
- CNT_W, 16, counter and period width
- DIV_W, 8, prescaler divide-register width

Ports:
- chosen_clk  input  1  selected timer clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- core_en  input  1  run enable (ctrl[2] & ~ctrl[1])
- cont  input  1  1 = continuous, 0 = one-shot (ctrl[3])
- cnt_clr  input  1  synchronous clear request (cnt_rst from timer_core)
- period_reg  input  CNT_W  terminal count
- div_reg  input  DIV_W  prescale: tick every div_reg+1 clocks
- cnt  output  CNT_W  main counter value
- cnt_tick  output  1  one-cycle strobe, high in the cycle cnt updates
- wrap  output  1  one-cycle strobe on a continuous-mode rollover
- done  output  1  level: one-shot has reached the period and is holding
- busy  output  1  level: FSM is in RUN

Behaviour:
- Reset (async, rst=1):
  - cnt=0, prescaler=0, cnt_tick=0, wrap=0, done=0, busy=0.
  - State is IDLE.
  - Reset mid-operation aborts immediately; there is no resume.
- Prescaler:
  - Counts 0..div_reg while in RUN.
  - When it equals div_reg, the next edge sets it to 0 and fires a tick.
  - div_reg=0 gives a tick every cycle.
  - div_reg is sampled live; if the prescaler is already above a newly written div_reg, it wraps at the next edge.
- FSM states:
  - IDLE: cnt and prescaler held at 0.
    - core_en=1 -> RUN next cycle.
  - RUN: on each tick:
    - If cnt >= period_reg:
      - cont=1 -> cnt=0, wrap=1 for one cycle, stay in RUN.
      - cont=0 -> cnt holds, state -> DONE, done=1.
    - Else cnt = cnt+1.
    - cnt_tick=1 on every tick.
  - DONE: cnt frozen; done=1; no ticks.
    - Leaves on cnt_clr=1 or core_en=0.
- Terminal compare uses >=, so a period lowered below the current cnt wraps or stops on the next tick. No 16-bit overflow is possible: at cnt=0xFFFF the terminal condition is true for any period_reg.
- period_reg=0:
  - cont=1: cnt stays 0 and wrap fires on every tick.
  - cont=0: DONE on the first tick.
- cnt_clr (synchronous, highest priority after reset):
  - Next edge sets cnt=0 and prescaler=0.
  - No tick or wrap is generated in that cycle.
  - State -> RUN if core_en=1, else IDLE.
  - cnt_clr coincident with a tick: the clear wins and the tick is dropped.
- core_en=0 in any state:
  - Next edge -> IDLE, cnt=0, prescaler=0, done=0.
- cont is sampled at the tick; changing it mid-run affects only the next terminal event.
- Output timing:
  - All outputs are registered.
  - Strobes are exactly one chosen_clk wide.
  - cnt is valid to timer_core one cycle after the tick edge.
- busy=1 iff state==RUN.

Optional Feature:
- TIMER_PRESCALER_EN defined:
  - Prescaler is instantiated as described above.
- Not defined:
  - div_reg is ignored (unconnected) and tick=1 every RUN cycle.
  - Prescaler flops are removed.
  - Otherwise identical; timing equals the div_reg=0 case.

Decomposition:
- Shared package timer_pkg:
  - CNT_W and DIV_W defaults.
  - 2-bit state encoding: IDLE=0, RUN=1, DONE=2.
- One sub-module, timer_prescaler:
  - Inputs: en, clr, div_reg.
  - Output: tick.
  - Instantiated only under TIMER_PRESCALER_EN.

Test Plan:
1. Reset then free run: rst pulse, core_en=1, cont=1, div_reg=0, period_reg=3 -> cnt sequence 0,1,2,3,0,1; wrap high in the cycle cnt returns 0; done=0.
2. Prescale: div_reg=2, period_reg=5, cont=1 -> cnt increments every 3 cycles; cnt_tick period 3; wrap every 18 cycles. (With the macro off, increments every cycle.)
3. One-shot: cont=0, period_reg=4, div_reg=0 -> cnt 0..4; done=1 and busy=0 thereafter; cnt frozen at 4 for 20 cycles; cnt_clr pulse -> cnt=0, busy=1, done=0.
4. Clear vs tick collision: period_reg=10, assert cnt_clr in a tick cycle at cnt=6 -> next cnt=0, no cnt_tick, no wrap; counting resumes 1,2,...
5. Period shrink and edge values: running at cnt=9, write period_reg=5 -> next tick wraps to 0 with wrap=1. period_reg=0, cont=1 -> cnt stays 0 and wrap every tick.
6. Async reset and disable mid-run: assert rst between edges at cnt=7 -> all outputs 0 immediately. Separately, core_en=0 at cnt=7 -> IDLE and cnt=0 next edge.
